// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_pkg
// Description : Game-phase encodings and whack detector FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

    localparam logic [1:0] c_GAME_IDLE  = 2'b00;
    localparam logic [1:0] c_GAME_SETUP = 2'b01;
    localparam logic [1:0] c_GAME_PLAY  = 2'b10;
    localparam logic [1:0] c_GAME_OVER  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_ARMED   = 2'b01,
        S_LOCKOUT = 2'b10
    } whack_state_t;

endpackage : game_pkg
`default_nettype wire

// File: rtl/switch_sync.sv
`default_nettype none
// ============================================================================
// Module      : switch_sync
// Description : 2-flop synchronizer plus previous-value register; emits a
//               per-bit rising-edge vector.
// Revision    : 1.0 - initial release
// ============================================================================
module switch_sync #(
    parameter int WIDTH = 16
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] switch_i,
    output logic [WIDTH-1:0] rise_o
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;
    logic [WIDTH-1:0] r_prev;

    // The previous register tracks every cycle, so a switch raised while the
    // consumer ignores edges never produces a late rise.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            r_meta <= '0;
            r_sync <= '0;
            r_prev <= '0;
        end else begin
            r_meta <= switch_i;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign rise_o = r_sync & ~r_prev;

endmodule : switch_sync
`default_nettype wire

// File: rtl/whack_detector.sv
`default_nettype none
// ============================================================================
// Module      : whack_detector
// Description : Classifies switch presses as hits or misses against the mole
//               display, with post-event lockout and saturating scoring.
// Revision    : 1.0 - initial release
// ============================================================================
module whack_detector
    import game_pkg::*;
#(
    parameter int LOCKOUT_CYCLES = 1000000,
    parameter int CNT_W          = 8
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic [15:0]      switch_i,
    input  logic [15:0]      mole_i,
    input  logic [1:0]       game_state,
    output logic             whacked_o,
    output logic             miss_o,
    output logic [CNT_W-1:0] hit_count_o,
    output logic [CNT_W-1:0] miss_count_o
);

    localparam int                  c_LOCK_W    = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [c_LOCK_W-1:0] c_LOCK_LAST = c_LOCK_W'(LOCKOUT_CYCLES - 1);

    logic [15:0]         w_rise;
    logic                w_play;
    logic                w_any_edge;
    logic                w_hit;

    whack_state_t        r_state;
    logic [c_LOCK_W-1:0] r_lock_cnt;
    logic [CNT_W-1:0]    r_hit_cnt;
    logic [CNT_W-1:0]    r_miss_cnt;
    logic                r_whacked;
    logic                r_miss;
    logic                r_play_d;

    switch_sync #(
        .WIDTH (16)
    ) u_switch_sync (
        .clock_i  (clock_i),
        .reset_i  (reset_i),
        .switch_i (switch_i),
        .rise_o   (w_rise)
    );

    assign w_play     = (game_state == c_GAME_PLAY);
    assign w_any_edge = |w_rise;
    assign w_hit      = |(w_rise & mole_i);

    // r_play_d resets high so that arming needs a genuine entry into PLAY
    // after reset, not merely PLAY being held through it.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state    <= S_IDLE;
            r_lock_cnt <= '0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
            r_whacked  <= 1'b0;
            r_miss     <= 1'b0;
            r_play_d   <= 1'b1;
        end else begin
            r_whacked <= 1'b0;
            r_miss    <= 1'b0;
            r_play_d  <= w_play;
            if (!w_play) begin
                r_state    <= S_IDLE;
                r_lock_cnt <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (!r_play_d) begin
                            r_state    <= S_ARMED;
                            r_hit_cnt  <= '0;
                            r_miss_cnt <= '0;
                        end
                    end
                    S_ARMED: begin
                        if (w_any_edge) begin
                            r_state    <= S_LOCKOUT;
                            r_lock_cnt <= '0;
                            if (w_hit) begin
                                r_whacked <= 1'b1;
                                if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + CNT_W'(1);
                            end else begin
                                r_miss <= 1'b1;
                                if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + CNT_W'(1);
                            end
                        end
                    end
                    S_LOCKOUT: begin
                        if (r_lock_cnt == c_LOCK_LAST) begin
                            r_state    <= S_ARMED;
                            r_lock_cnt <= '0;
                        end else begin
                            r_lock_cnt <= r_lock_cnt + c_LOCK_W'(1);
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign whacked_o    = r_whacked;
    assign miss_o       = r_miss;
    assign hit_count_o  = r_hit_cnt;
    assign miss_count_o = r_miss_cnt;

endmodule : whack_detector
`default_nettype wire

// File: tb/tb_whack_detector.sv
`default_nettype none
// ============================================================================
// Module      : tb_whack_detector
// Description : Directed stimulus with a pulse scoreboard for whack_detector.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_whack_detector;

    logic        clock_i = 1'b0;
    logic        reset_i;
    logic [15:0] switch_i;
    logic [15:0] mole_i;
    logic [1:0]  game_state;
    logic        whacked_o;
    logic        miss_o;
    logic [7:0]  hit_count_o;
    logic [7:0]  miss_count_o;

    typedef struct {
        bit hit;
        int cyc;
    } ev_t;

    ev_t sb[$];
    int  cyc    = 0;
    int  errors = 0;
    int  checks = 0;

    whack_detector #(
        .LOCKOUT_CYCLES (8),
        .CNT_W          (8)
    ) dut (
        .clock_i      (clock_i),
        .reset_i      (reset_i),
        .switch_i     (switch_i),
        .mole_i       (mole_i),
        .game_state   (game_state),
        .whacked_o    (whacked_o),
        .miss_o       (miss_o),
        .hit_count_o  (hit_count_o),
        .miss_count_o (miss_count_o)
    );

    always #5 clock_i = ~clock_i;

    always @(posedge clock_i) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock_i);
    endtask

    // A press driven now is first sampled on the next rising edge (edge 1);
    // the pulse is expected to be visible after edge 3.
    task automatic press(input logic [15:0] bits, input bit expect_ev, input bit exp_hit);
        ev_t e;
        switch_i = bits;
        if (expect_ev) begin
            e.hit = exp_hit;
            e.cyc = cyc + 3;
            sb.push_back(e);
        end
    endtask

    always @(negedge clock_i) begin
        if (whacked_o || miss_o) begin
            chk("pulse_exclusive", int'(whacked_o & miss_o), 0);
            if (sb.size() == 0) begin
                chk("unexpected_pulse_whacked", int'(whacked_o), 0);
                chk("unexpected_pulse_miss", int'(miss_o), 0);
            end else begin
                ev_t e;
                e = sb.pop_front();
                chk("pulse_kind_whacked", int'(whacked_o), int'(e.hit));
                chk("pulse_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        reset_i    = 1'b0;
        switch_i   = '0;
        mole_i     = '0;
        game_state = 2'b00;
        tick(3);
        chk("reset_whacked", int'(whacked_o), 0);
        chk("reset_miss", int'(miss_o), 0);
        chk("reset_hits", int'(hit_count_o), 0);
        chk("reset_misses", int'(miss_count_o), 0);
        reset_i = 1'b1;
        tick(2);
        game_state = 2'b10;
        tick(1);

        // Hit on mole 5
        mole_i = 16'h0020;
        press(16'h0020, 1'b1, 1'b1);
        tick(3);
        chk("hit_count_after_hit", int'(hit_count_o), 1);
        chk("miss_count_after_hit", int'(miss_count_o), 0);
        switch_i = '0;
        tick(12);

        // Miss, then a correct press inside lockout must be dropped for good
        press(16'h0008, 1'b1, 1'b0);
        tick(2);
        press(16'h0028, 1'b0, 1'b0);
        tick(20);
        chk("miss_count_after_miss", int'(miss_count_o), 1);
        chk("hit_count_after_lockout", int'(hit_count_o), 1);
        switch_i = '0;
        tick(12);

        // Re-enter PLAY to clear, then simultaneous edges
        game_state = 2'b01;
        tick(2);
        game_state = 2'b10;
        tick(1);
        chk("reenter_hits_cleared", int'(hit_count_o), 0);
        chk("reenter_misses_cleared", int'(miss_count_o), 0);
        press(16'h0028, 1'b1, 1'b1);
        tick(3);
        chk("simul_hits", int'(hit_count_o), 1);
        chk("simul_misses", int'(miss_count_o), 0);
        switch_i = '0;
        tick(12);

        // Blank mole turns any press into a miss
        mole_i = '0;
        press(16'h0020, 1'b1, 1'b0);
        tick(3);
        chk("blank_mole_misses", int'(miss_count_o), 1);
        switch_i = '0;
        tick(12);

        // Saturation
        game_state = 2'b01;
        tick(2);
        game_state = 2'b10;
        tick(1);
        mole_i = 16'h0020;
        for (int i = 0; i < 260; i++) begin
            press(16'h0020, 1'b1, 1'b1);
            tick(3);
            switch_i = '0;
            tick(10);
        end
        chk("saturated_hits", int'(hit_count_o), 255);
        chk("saturated_misses", int'(miss_count_o), 0);

        // Leaving PLAY: edges ignored, counts held
        game_state = 2'b01;
        tick(1);
        press(16'h0020, 1'b0, 1'b0);
        tick(6);
        press(16'h0000, 1'b0, 1'b0);
        tick(3);
        press(16'h0008, 1'b0, 1'b0);
        tick(6);
        switch_i = '0;
        tick(3);
        chk("held_hits", int'(hit_count_o), 255);
        chk("held_misses", int'(miss_count_o), 0);
        game_state = 2'b10;
        tick(1);
        chk("play_again_hits", int'(hit_count_o), 0);

        // Reset during lockout
        press(16'h0008, 1'b1, 1'b0);
        tick(3);
        chk("pre_reset_misses", int'(miss_count_o), 1);
        tick(2);
        reset_i = 1'b0;
        #1;
        chk("async_reset_whacked", int'(whacked_o), 0);
        chk("async_reset_miss", int'(miss_o), 0);
        chk("async_reset_hits", int'(hit_count_o), 0);
        chk("async_reset_misses", int'(miss_count_o), 0);
        switch_i   = '0;
        game_state = 2'b00;
        tick(2);
        reset_i = 1'b1;
        tick(3);
        game_state = 2'b10;
        tick(1);
        press(16'h0020, 1'b1, 1'b1);
        tick(3);
        chk("post_reset_hits", int'(hit_count_o), 1);
        switch_i = '0;
        tick(12);

        chk("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_whack_detector
`default_nettype wire

// File: doc/whack_detector.md
WHACK_DETECTOR -- requirements
Module: whack_detector

Interface
REQ-001 SHALL have parameter LOCKOUT_CYCLES, default 1000000, meaning the number of clock_i cycles that edges are ignored after a hit or miss (10 ms at 100 MHz).
REQ-002 SHALL have parameter CNT_W, default 8, meaning the width of the hit and miss counters.
REQ-003 SHALL have port clock_i, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_i, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port switch_i, input, 16 bits: raw, asynchronous board switches/buttons; bit k targets mole position k.
REQ-006 SHALL have port mole_i, input, 16 bits: the one-hot (or all-zero) mole display currently driven to the board.
REQ-007 SHALL have port game_state, input, 2 bits: the game phase; 2'b10 = PLAY.
REQ-008 SHALL have port whacked_o, output, 1 bit: one-cycle pulse on a hit; drives the mole handler's whacked input.
REQ-009 SHALL have port miss_o, output, 1 bit: one-cycle pulse on a miss.
REQ-010 SHALL have port hit_count_o, output, CNT_W bits: saturating hit count.
REQ-011 SHALL have port miss_count_o, output, CNT_W bits: saturating miss count.

Function
REQ-012 SHALL pass switch_i through a 2-flop synchronizer and then a third "previous" register; a press is a rising edge, defined as synchronized bit = 1 and previous bit = 0.
REQ-013 SHALL implement states IDLE, ARMED and LOCKOUT.
REQ-014 SHALL move IDLE -> ARMED on the cycle game_state becomes 2'b10, and SHALL clear both counters on that same cycle.
REQ-015 In ARMED, SHALL classify any rising edge, registered together with the mole_i value present in that cycle: if the edge bits AND mole_i is non-zero, the event is a hit; otherwise it is a miss.
REQ-016 A hit SHALL pulse whacked_o for exactly one cycle and increment hit_count_o; a miss SHALL pulse miss_o for exactly one cycle and increment miss_count_o; either event SHALL move ARMED -> LOCKOUT.
REQ-017 Latency: whacked_o/miss_o SHALL assert on the 3rd rising clock_i edge, counting the edge that first samples switch_i high as edge 1.
REQ-018 Multiple simultaneous edge bits SHALL produce one event only; the event is a hit if any edge bit matches mole_i.
REQ-019 mole_i = 0 (mole blanked or already whacked) SHALL make any edge a miss.
REQ-020 In LOCKOUT, SHALL ignore all edges for LOCKOUT_CYCLES cycles, then return to ARMED; edges of switches that went high during lockout SHALL NOT fire later (the previous register keeps tracking).
REQ-021 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-022 When game_state leaves 2'b10 in any state, SHALL go to IDLE on the next edge, abort any lockout (counter to 0), emit no pulses, and hold both counts.
REQ-023 whacked_o and miss_o SHALL never be high in the same cycle.

Reset
REQ-024 reset_i low SHALL asynchronously force: state IDLE; whacked_o, miss_o = 0; both counters = 0; lockout counter = 0; all synchronizer and previous registers = 0.
REQ-025 Reset asserted mid-lockout or mid-pulse SHALL take effect immediately; after release the block SHALL wait in IDLE for a game_state transition into 2'b10.

Structure
REQ-026 Game-state encodings (including PLAY = 2'b10) and the FSM state enumeration SHALL live in the shared package game_pkg.
REQ-027 Synchronizer plus edge detect SHALL be one sub-module, switch_sync (16-bit, outputs a per-bit rise vector); the FSM, lockout counter and scoring SHALL be in whack_detector.

Verification (LOCKOUT_CYCLES=8, CNT_W=8)
REQ-028 Bench SHALL cover a hit: PLAY, mole_i=16'h0020, raise switch_i[5] -> whacked_o high for exactly 1 cycle at edge 3, hit_count_o=1, miss_o stays 0.
REQ-029 Bench SHALL cover a miss and lockout: mole_i=16'h0020, raise switch_i[3] -> miss_o pulse, miss_count_o=1; raise switch_i[5] 2 cycles later -> no pulse, and no delayed pulse after lockout ends.
REQ-030 Bench SHALL cover simultaneous edges: switch_i 0 -> 16'h0028 with mole_i=16'h0020 -> single whacked_o pulse, hit_count_o=1, miss_count_o=0.
REQ-031 Bench SHALL cover saturation: 260 hits separated by lockouts -> hit_count_o=255.
REQ-032 Bench SHALL cover reset and exit from PLAY: reset_i low during LOCKOUT -> all outputs 0 immediately; game_state=2'b01 with edges -> no pulses, counts held; re-enter 2'b10 -> counts 0.
